// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the two-wide instruction fetch queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 8;
  localparam int unsigned FQ_WIDTH         = 32;

  typedef struct packed {
    logic [FQ_WIDTH-1:0] pc;
    logic [FQ_WIDTH-1:0] inst;
  } fq_entry_t;

  // Number of entries carried by a slot-valid vector; the illegal 10 counts as nothing.
  function automatic logic [1:0] fq_slot_cnt(input logic [1:0] valid);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (valid == 2'b11) cnt = 2'd2;
    else if (valid == 2'b01) cnt = 2'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the fetch queue circular buffer.
module fq_ptr_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [1:0]       push_cnt_i,
  input  logic [1:0]       pop_cnt_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       pop_eff;

  // Never retire more entries than are actually held.
  always_comb begin
    pop_eff = pop_cnt_i;
    if (CNT_W'(pop_cnt_i) > count_q) pop_eff = 2'(count_q);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q + PTR_W'(push_cnt_i);
      count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch queue: buffers {PC, inst} pairs between fetch and decode with show-ahead reads.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = FQ_WIDTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_pc0,
  input  logic [WIDTH-1:0] in_inst0,
  input  logic [WIDTH-1:0] in_pc1,
  input  logic [WIDTH-1:0] in_inst1,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [WIDTH-1:0] out_pc0,
  output logic [WIDTH-1:0] out_inst0,
  output logic [WIDTH-1:0] out_pc1,
  output logic [WIDTH-1:0] out_inst1,
  input  logic [1:0]       pop_cnt,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       push_cnt;
  fq_entry_t        wr0, wr1, rd0, rd1;

  // Ready looks only at registered occupancy so fetch never waits on decode's pop.
  assign in_ready = (DEPTH_C - count_q) >= CNT_W'(2);
  assign push_cnt = (in_ready && !flush) ? fq_slot_cnt(in_valid) : 2'd0;

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_cnt_i (push_cnt),
    .pop_cnt_i  (flush ? 2'd0 : pop_cnt),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (count_q)
  );

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  assign wr0 = '{pc: FQ_WIDTH'(in_pc0), inst: FQ_WIDTH'(in_inst0)};
  assign wr1 = '{pc: FQ_WIDTH'(in_pc1), inst: FQ_WIDTH'(in_inst1)};

  // Storage is intentionally unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[tail] <= wr0;
    if (push_cnt == 2'd2) mem[tail_p1] <= wr1;
  end

  assign rd0 = mem[head];
  assign rd1 = mem[head_p1];

  always_comb begin
    out_valid = 2'b11;
    if (count_q == '0) out_valid = 2'b00;
    else if (count_q == CNT_W'(1)) out_valid = 2'b01;
  end

  assign out_pc0   = WIDTH'(rd0.pc);
  assign out_inst0 = WIDTH'(rd0.inst);
  assign out_pc1   = WIDTH'(rd1.pc);
  assign out_inst1 = WIDTH'(rd1.inst);
  assign count     = count_q;

  // Upstream protocol checks; the datapath above already tolerates violations.
  always @(posedge clk) begin
    if (!rst) begin
      assert (in_valid != 2'b10);
      assert (pop_cnt != 2'd3 && CNT_W'(pop_cnt) <= count_q);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [1:0]  pop_cnt;
  logic [3:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] model_q[$];
  logic [31:0] next_pc;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc0    (in_pc0),
    .in_inst0  (in_inst0),
    .in_pc1    (in_pc1),
    .in_inst1  (in_inst1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc0   (out_pc0),
    .out_inst0 (out_inst0),
    .out_pc1   (out_pc1),
    .out_inst1 (out_inst1),
    .pop_cnt   (pop_cnt),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against what the model's queue contents imply.
  task automatic check_outputs(input string tag);
    int sz;
    logic [1:0] exp_valid;
    sz = model_q.size();
    exp_valid = (sz == 0) ? 2'b00 : (sz == 1) ? 2'b01 : 2'b11;
    chk({tag, ":count"}, 64'(count), 64'(sz));
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(exp_valid));
    chk({tag, ":in_ready"}, 64'(in_ready), 64'((DEPTH - sz) >= 2));
    if (sz >= 1) begin
      chk({tag, ":out_pc0"}, 64'(out_pc0), 64'(model_q[0][63:32]));
      chk({tag, ":out_inst0"}, 64'(out_inst0), 64'(model_q[0][31:0]));
    end
    if (sz >= 2) begin
      chk({tag, ":out_pc1"}, 64'(out_pc1), 64'(model_q[1][63:32]));
      chk({tag, ":out_inst1"}, 64'(out_inst1), 64'(model_q[1][31:0]));
    end
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic fl, input logic [1:0] vin,
                      input logic [31:0] pc0, input logic [1:0] pop);
    bit accept;
    flush    = fl;
    in_valid = vin;
    in_pc0   = pc0;
    in_pc1   = pc0 + 32'd4;
    in_inst0 = $urandom;
    in_inst1 = $urandom;
    pop_cnt  = pop;
    accept   = !fl && vin != 2'b00 && (DEPTH - model_q.size()) >= 2;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      for (int i = 0; i < int'(pop); i++) void'(model_q.pop_front());
      if (accept) begin
        model_q.push_back({in_pc0, in_inst0});
        if (vin == 2'b11) model_q.push_back({in_pc1, in_inst1});
      end
    end
    if (accept) next_pc = pc0 + ((vin == 2'b11) ? 32'd8 : 32'd4);
    #1;
    flush    = 1'b0;
    in_valid = 2'b00;
    pop_cnt  = 2'd0;
    check_outputs(tag);
  endtask

  task automatic do_flush();
    step("flush", 1'b1, 2'b00, 32'h0, 2'd0);
  endtask

  initial begin
    logic [1:0] vin;
    logic [1:0] pop;
    int         sz;
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; pop_cnt = 2'd0;
    in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
    next_pc = 32'h1000;
    #12;
    check_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_outputs("post_reset");

    // Fill to DEPTH; a further push must be refused.
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 2'b11, next_pc, 2'd0);
    chk("fill:count8", 64'(count), 64'd8);
    chk("fill:not_ready", 64'(in_ready), 64'd0);
    step("fill_over", 1'b0, 2'b11, 32'hDEAD0000, 2'd0);
    chk("fill_over:count8", 64'(count), 64'd8);

    // Order and dual pop.
    do_flush();
    step("order_a", 1'b0, 2'b11, 32'h3000, 2'd0);
    step("order_b", 1'b0, 2'b11, 32'h3008, 2'd0);
    step("order_pop", 1'b0, 2'b00, 32'h0, 2'd2);
    chk("order:pc0", 64'(out_pc0), 64'h3008);
    chk("order:pc1", 64'(out_pc1), 64'h300C);
    chk("order:valid", 64'(out_valid), 64'b11);

    // Wrap-around at steady occupancy of 6.
    do_flush();
    next_pc = 32'h4000;
    for (int i = 0; i < 3; i++) step("wrap_fill", 1'b0, 2'b11, next_pc, 2'd0);
    for (int i = 0; i < 20; i++) step("wrap", 1'b0, 2'b11, next_pc, 2'd2);
    chk("wrap:count6", 64'(count), 64'd6);

    // Simultaneous push 01 and pop 2 from count 3.
    do_flush();
    next_pc = 32'h5000;
    step("sim_fill", 1'b0, 2'b11, next_pc, 2'd0);
    step("sim_fill", 1'b0, 2'b01, next_pc, 2'd0);
    step("sim", 1'b0, 2'b01, 32'h5100, 2'd2);
    chk("sim:count2", 64'(count), 64'd2);
    chk("sim:new_at_pc1", 64'(out_pc1), 64'h5100);

    // Flush overrides push and pop; next push lands at index 0.
    do_flush();
    next_pc = 32'h6000;
    for (int i = 0; i < 3; i++) step("fl_fill", 1'b0, 2'b11, next_pc, 2'd0);
    step("fl_fill", 1'b0, 2'b01, next_pc, 2'd0);
    chk("fl:count7", 64'(count), 64'd7);
    step("fl", 1'b1, 2'b11, 32'h7000, 2'd1);
    chk("fl:count0", 64'(count), 64'd0);
    chk("fl:head0", 64'(dut.u_ptr.head_o), 64'd0);
    chk("fl:tail0", 64'(dut.u_ptr.tail_o), 64'd0);
    step("fl_push", 1'b0, 2'b01, 32'h7100, 2'd0);
    chk("fl:mem0_pc", 64'(dut.mem[0].pc), 64'h7100);

    // Random legal traffic.
    next_pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      sz = model_q.size();
      case ($urandom_range(0, 2))
        0: vin = 2'b00;
        1: vin = 2'b01;
        default: vin = 2'b11;
      endcase
      pop = 2'($urandom_range(0, (sz < 2) ? sz : 2));
      step("rand", ($urandom_range(0, 39) == 0), vin, next_pc, pop);
    end

    // Async reset with count 5, observed before any clock edge.
    do_flush();
    for (int i = 0; i < 2; i++) step("rst_fill", 1'b0, 2'b11, next_pc, 2'd0);
    step("rst_fill", 1'b0, 2'b01, next_pc, 2'd0);
    chk("rst:count5", 64'(count), 64'd5);
    #2 rst = 1'b1;
    model_q.delete();
    #1;
    check_outputs("async_rst");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_outputs("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
